// File: rtl/puf_pkg.sv
// ---------------------------------------------------------------------------
// puf_pkg
// Shared types and constants for the ring-oscillator PUF evaluation
// controller: FSM state encoding, synchroniser depth, drain length and the
// count-enable delay that lines the counters up with the synchronised rings.
// ---------------------------------------------------------------------------
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONFIG = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Flops between the asynchronous ring output and the edge detector.
  localparam int SYNC_STAGES = 2;

  // Cycles spent after RUN so the last ring edges reach the counters.
  localparam int DRAIN_CYC   = 3;

  // RO_EN to count-enable delay: two synchroniser flops plus the
  // edge-detector register.
  localparam int EN_DELAY    = 3;

  // Phase timer width; holds WINDOW-1 for WINDOW up to 2^20.
  localparam int TMR_W       = 21;

endpackage

// File: rtl/ro_edge_counter.sv
// ---------------------------------------------------------------------------
// ro_edge_counter
// Synchronises one asynchronous ring-oscillator output, detects its rising
// edges and counts them with a saturating counter.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset (clears the count)
//   ring       in   asynchronous ring output
//   clr        in   clear the count (start of an evaluation)
//   en         in   count enable, already aligned to the synchronised edges
//   count_next out  value the count register takes at the next edge; lets the
//                   caller register a result that includes a final increment
// ---------------------------------------------------------------------------
module ro_edge_counter
  import puf_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ring,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count_next
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   lvl_p1;
  logic                   rise;
  logic [CNT_W-1:0]       count;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Stage p0: two-flop synchroniser on the asynchronous ring output.
  always_ff @(posedge clk) begin
    sync_p0 <= {sync_p0[SYNC_STAGES-2:0], ring};
  end

  // Stage p1: previous synchronised level for rising-edge detection.
  always_ff @(posedge clk) begin
    lvl_p1 <= sync_p0[SYNC_STAGES-1];
  end

  assign rise = sync_p0[SYNC_STAGES-1] & ~lvl_p1;

  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else if (en && rise) begin
      count_next = sat_inc(count);
    end
  end

  // Stage p2: saturating edge counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/ro_puf_eval_ctrl.sv
// ---------------------------------------------------------------------------
// ro_puf_eval_ctrl
// Evaluation controller for a two-chain ring-oscillator PUF. A challenge is
// accepted through START/BUSY, applied to the SEL/BX lines of both chains,
// the rings are enabled for WINDOW cycles, the synchronised rising edges of
// each ring are counted, and one response bit (count A > count B) is
// returned with a single-cycle VALID strobe.
//
// Ports:
//   CLK     in   system clock, all logic on the rising edge
//   RST     in   synchronous active-high reset
//   START   in   evaluation request, only looked at in IDLE
//   CHAL    in   challenge: low half -> RO_SEL, high half -> RO_BX
//   BUSY    out  high in every state except IDLE
//   RO_EN   out  ring enable, high only in RUN
//   RO_SEL  out  per-slice LUT select (latched challenge, CONFIG..DRAIN)
//   RO_BX   out  per-slice output-mux select (latched challenge, CONFIG..DRAIN)
//   RO_A    in   asynchronous output of ring A
//   RO_B    in   asynchronous output of ring B
//   RESP    out  response bit, held until the next DONE
//   VALID   out  one-cycle strobe in DONE
//   CNT_A   out  final count of ring A (only with PUF_RAW_COUNT_EN)
//   CNT_B   out  final count of ring B (only with PUF_RAW_COUNT_EN)
//
// Build option: define PUF_RAW_COUNT_EN to expose the raw final counts on
// CNT_A/CNT_B. Without it the counts stay internal; the response is the same.
// ---------------------------------------------------------------------------
module ro_puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int N_STAGES = 8,
  parameter int CNT_W    = 16,
  parameter int WINDOW   = 1000,
  parameter int SETTLE   = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [2*N_STAGES-1:0] CHAL,
  output logic                  BUSY,
  output logic                  RO_EN,
  output logic [N_STAGES-1:0]   RO_SEL,
  output logic [N_STAGES-1:0]   RO_BX,
  input  logic                  RO_A,
  input  logic                  RO_B,
  output logic                  RESP,
  output logic                  VALID
`ifdef PUF_RAW_COUNT_EN
  ,
  output logic [CNT_W-1:0]      CNT_A,
  output logic [CNT_W-1:0]      CNT_B
`endif
);

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);
  localparam logic [TMR_W-1:0] DRAIN_LAST  = TMR_W'(DRAIN_CYC - 1);

  state_t                state;
  state_t                state_nxt;
  logic [TMR_W-1:0]      tmr;
  logic                  start_acc;
  logic                  chal_live;
  logic                  drain_last;
  logic [2*N_STAGES-1:0] chal_q;
  logic [EN_DELAY-1:0]   en_dly;
  logic                  cnt_en;
  logic [CNT_W-1:0]      cnt_a_nxt;
  logic [CNT_W-1:0]      cnt_b_nxt;

  assign start_acc  = (state == IDLE) && START;
  assign drain_last = (state == DRAIN) && (tmr == DRAIN_LAST);

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Phase timer: restarts at every state change, parked at zero in IDLE.
  always_ff @(posedge CLK) begin
    if (RST || (state == IDLE) || (state_nxt != state)) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + TMR_W'(1);
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (START)              state_nxt = CONFIG;
      CONFIG:  if (tmr == SETTLE_LAST) state_nxt = RUN;
      RUN:     if (tmr == WINDOW_LAST) state_nxt = DRAIN;
      DRAIN:   if (tmr == DRAIN_LAST)  state_nxt = DONE;
      DONE:                            state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    BUSY      = (state != IDLE);
    RO_EN     = (state == RUN);
    VALID     = (state == DONE);
    chal_live = (state == CONFIG) || (state == RUN) || (state == DRAIN);
  end

  assign RO_SEL = chal_live ? chal_q[N_STAGES-1:0]          : '0;
  assign RO_BX  = chal_live ? chal_q[2*N_STAGES-1:N_STAGES] : '0;

  // Challenge latch: only written on acceptance, so later CHAL changes are
  // invisible to the rings. Outside CONFIG..DRAIN the lines are forced low,
  // so the latch itself needs no reset.
  always_ff @(posedge CLK) begin
    if (start_acc) begin
      chal_q <= CHAL;
    end
  end

  // Count-enable delay line: RO_EN shifted by the synchroniser plus edge
  // register depth, so each counter sees exactly WINDOW enabled cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      en_dly <= '0;
    end else begin
      en_dly <= {en_dly[EN_DELAY-2:0], RO_EN};
    end
  end

  assign cnt_en = en_dly[EN_DELAY-1];

  ro_edge_counter #(
    .CNT_W (CNT_W)
  ) u_cnt_a (
    .clk        (CLK),
    .rst        (RST),
    .ring       (RO_A),
    .clr        (start_acc),
    .en         (cnt_en),
    .count_next (cnt_a_nxt)
  );

  ro_edge_counter #(
    .CNT_W (CNT_W)
  ) u_cnt_b (
    .clk        (CLK),
    .rst        (RST),
    .ring       (RO_B),
    .clr        (start_acc),
    .en         (cnt_en),
    .count_next (cnt_b_nxt)
  );

  // Compare stage: the last counter increment lands on the same edge that
  // closes DRAIN, so the compare takes the counters' next values.
  // Equal counts (including both saturated) give 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RESP <= 1'b0;
    end else if (drain_last) begin
      RESP <= (cnt_a_nxt > cnt_b_nxt);
    end
  end

`ifdef PUF_RAW_COUNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      CNT_A <= '0;
      CNT_B <= '0;
    end else if (drain_last) begin
      CNT_A <= cnt_a_nxt;
      CNT_B <= cnt_b_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_ro_puf_eval_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ro_puf_eval_ctrl
// Directed bench for ro_puf_eval_ctrl. Ring outputs are modelled as square
// waves with programmable half-periods. Each accepted START pushes the
// expected response and VALID cycle to a queue; a monitor pops and compares
// when VALID is seen. A second instance with CNT_W=4 covers saturation.
// ---------------------------------------------------------------------------
module tb_ro_puf_eval_ctrl;

  localparam int S = 4;
  localparam int W = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start_s;
  logic [15:0] chal;
  logic        busy, ro_en, resp, valid;
  logic [7:0]  ro_sel, ro_bx;
  logic        busy_s, ro_en_s, resp_s, valid_s;
  logic [7:0]  ro_sel_s, ro_bx_s;
  logic        ro_a, ro_b, same;
`ifdef PUF_RAW_COUNT_EN
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_a_s, cnt_b_s;
`endif

  int   half[4] = '{2, 4, 2, 3};
  int   ctr[4]  = '{default: 0};
  logic ring[4] = '{1'b0, 1'b0, 1'b0, 1'b0};

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int t0     = 0;

  typedef struct {
    logic resp;
    int   due;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Ring models: toggle every half[i] cycles, changing on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ctr[i] + 1 >= half[i]) begin
        ctr[i]  <= 0;
        ring[i] <= ~ring[i];
      end else begin
        ctr[i] <= ctr[i] + 1;
      end
    end
  end

  assign ro_a = ring[0];
  assign ro_b = same ? ring[0] : ring[1];

  ro_puf_eval_ctrl #(
    .N_STAGES (8), .CNT_W (16), .WINDOW (W), .SETTLE (S)
  ) dut (
    .CLK (clk), .RST (rst), .START (start), .CHAL (chal),
    .BUSY (busy), .RO_EN (ro_en), .RO_SEL (ro_sel), .RO_BX (ro_bx),
    .RO_A (ro_a), .RO_B (ro_b), .RESP (resp), .VALID (valid)
`ifdef PUF_RAW_COUNT_EN
    , .CNT_A (cnt_a), .CNT_B (cnt_b)
`endif
  );

  ro_puf_eval_ctrl #(
    .N_STAGES (8), .CNT_W (4), .WINDOW (W), .SETTLE (S)
  ) dut_s (
    .CLK (clk), .RST (rst), .START (start_s), .CHAL (16'h0000),
    .BUSY (busy_s), .RO_EN (ro_en_s), .RO_SEL (ro_sel_s), .RO_BX (ro_bx_s),
    .RO_A (ring[2]), .RO_B (ring[3]), .RESP (resp_s), .VALID (valid_s)
`ifdef PUF_RAW_COUNT_EN
    , .CNT_A (cnt_a_s), .CNT_B (cnt_b_s)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one evaluation on the main instance; t0 is the sampling edge.
  task automatic start_eval(input logic exp_resp);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
    e.resp = exp_resp;
    e.due  = t0 + S + W + 3;
    q.push_back(e);
  endtask

  // Move to the falling edge inside cycle t+n (n counted from the START edge).
  task automatic wait_rel(input int n);
    do @(negedge clk); while (cyc < t0 + n - 1);
  endtask

  // Scoreboard monitor on the main instance.
  always @(negedge clk) begin
    if (valid) begin
      if (q.size() == 0) begin
        check("spurious_valid", 32'(valid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("resp", 32'(resp), 32'(e.resp));
        check("valid_cycle", 32'(cyc), 32'(e.due));
      end
    end else if (q.size() > 0 && cyc > q[0].due) begin
      check("valid_missing", 32'(valid), 32'd1);
      void'(q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    start_s = 1'b0;
    chal    = 16'h0000;
    same    = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  32'(busy),   32'd0);
    check("rst_ro_en", 32'(ro_en),  32'd0);
    check("rst_sel",   32'(ro_sel), 32'd0);
    check("rst_bx",    32'(ro_bx),  32'd0);
    check("rst_resp",  32'(resp),   32'd0);
    check("rst_valid", 32'(valid),  32'd0);
`ifdef PUF_RAW_COUNT_EN
    check("rst_cnt_a", 32'(cnt_a), 32'd0);
    check("rst_cnt_b", 32'(cnt_b), 32'd0);
`endif
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // A fast (period 4), B slow (period 8): RESP=1, challenge routing,
    // CHAL change mid-RUN, START pulses in RUN and DONE ignored.
    half[0] = 2;
    half[1] = 4;
    chal    = 16'hA53C;
    start_eval(1'b1);
    wait_rel(1);
    check("cfg_busy",  32'(busy),   32'd1);
    check("cfg_ro_en", 32'(ro_en),  32'd0);
    check("cfg_sel",   32'(ro_sel), 32'h3C);
    check("cfg_bx",    32'(ro_bx),  32'hA5);
    wait_rel(4);
    check("cfg_end_ro_en", 32'(ro_en), 32'd0);
    wait_rel(5);
    check("run_start_ro_en", 32'(ro_en), 32'd1);
    wait_rel(30);
    start = 1'b1;
    wait_rel(31);
    start = 1'b0;
    wait_rel(50);
    chal = 16'h0000;
    wait_rel(60);
    check("run_sel_held", 32'(ro_sel), 32'h3C);
    check("run_bx_held",  32'(ro_bx),  32'hA5);
    wait_rel(104);
    check("run_end_ro_en", 32'(ro_en), 32'd1);
    wait_rel(105);
    check("drain_ro_en", 32'(ro_en),  32'd0);
    check("drain_sel",   32'(ro_sel), 32'h3C);
    check("drain_bx",    32'(ro_bx),  32'hA5);
    check("drain_busy",  32'(busy),   32'd1);
    wait_rel(108);
    start = 1'b1;
    check("done_sel", 32'(ro_sel), 32'd0);
    check("done_bx",  32'(ro_bx),  32'd0);
    wait_rel(109);
    start = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    wait_rel(110);
    check("idle_busy_after_done_start", 32'(busy), 32'd0);
    check("resp_held", 32'(resp), 32'd1);
    check("count_a_fast", 32'(dut.u_cnt_a.count), 32'd25);
    check("count_b_slow", 32'((dut.u_cnt_b.count == 16'd12) || (dut.u_cnt_b.count == 16'd13)), 32'd1);
`ifdef PUF_RAW_COUNT_EN
    check("raw_cnt_a", 32'(cnt_a), 32'd25);
    check("raw_cnt_b", 32'((cnt_b == 16'd12) || (cnt_b == 16'd13)), 32'd1);
`endif
    repeat (120) @(negedge clk);

    // Swapped rates: RESP=0.
    half[0] = 4;
    half[1] = 2;
    chal    = 16'h1234;
    start_eval(1'b0);
    wait_rel(110);
    check("swap_count_b", 32'(dut.u_cnt_b.count), 32'd25);
    check("swap_resp", 32'(resp), 32'd0);

    // Identical waveforms: tie gives RESP=0.
    half[0] = 3;
    same    = 1'b1;
    start_eval(1'b0);
    wait_rel(110);
    check("tie_counts_equal", 32'(dut.u_cnt_a.count == dut.u_cnt_b.count), 32'd1);
    same = 1'b0;

    // Reset in the middle of RUN: ring off next cycle, no VALID.
    half[0] = 2;
    half[1] = 4;
    start_eval(1'b1);
    wait_rel(50);
    q.delete();
    rst = 1'b1;
    @(negedge clk);
    check("rst_run_ro_en", 32'(ro_en),  32'd0);
    check("rst_run_busy",  32'(busy),   32'd0);
    check("rst_run_sel",   32'(ro_sel), 32'd0);
    rst = 1'b0;
    repeat (150) @(negedge clk);

    // Clean evaluation after the aborted one.
    start_eval(1'b1);
    wait_rel(110);
    check("post_rst_count_a", 32'(dut.u_cnt_a.count), 32'd25);
    check("post_rst_resp",    32'(resp), 32'd1);
    check("queue_drained",    32'(q.size()), 32'd0);

    // Saturation on the 4-bit instance: both counters pin at 15, tie -> 0.
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (valid_s) begin
          seen = 1'b1;
          break;
        end
      end
      check("sat_valid_seen", 32'(seen), 32'd1);
      check("sat_resp", 32'(resp_s), 32'd0);
      check("sat_count_a", 32'(dut_s.u_cnt_a.count), 32'd15);
      check("sat_count_b", 32'(dut_s.u_cnt_b.count), 32'd15);
`ifdef PUF_RAW_COUNT_EN
      check("sat_raw_a", 32'(cnt_a_s), 32'd15);
      check("sat_raw_b", 32'(cnt_b_s), 32'd15);
`endif
    end
    @(negedge clk);
    check("sat_idle_busy",  32'(busy_s),   32'd0);
    check("sat_idle_ro_en", 32'(ro_en_s),  32'd0);
    check("sat_idle_sel",   32'({ro_sel_s, ro_bx_s}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
